// File: rtl/pp_bank_sched_if.sv
// rtl/pp_bank_sched_if.sv - capture and reader signal bundle for the ping-pong bank scheduler
interface pp_bank_sched_if #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
);
    logic              soft_rst;
    logic              enable;
    logic              data_en;
    logic              flush;
    logic              rd_done_tgl;
    logic [1:0]        bank_wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [1:0]        bank_full;
    logic              rd_bank_vld;
    logic              rd_bank_id;
    logic [ADDR_W:0]   rd_len;
    logic              drop_pulse;
    logic [CNT_W-1:0]  drop_cnt;
    logic              proto_err;

    modport master (
        output soft_rst, enable, data_en, flush, rd_done_tgl,
        input  bank_wr_en, wr_addr, bank_full, rd_bank_vld, rd_bank_id, rd_len,
               drop_pulse, drop_cnt, proto_err
    );

    modport slave (
        input  soft_rst, enable, data_en, flush, rd_done_tgl,
        output bank_wr_en, wr_addr, bank_full, rd_bank_vld, rd_bank_id, rd_len,
               drop_pulse, drop_cnt, proto_err
    );
endinterface

// File: rtl/pp_bank_sched.sv
// rtl/pp_bank_sched.sv - ping-pong capture buffer write scheduler (clk_50m domain)
// Optional partial-bank close on flush: PP_SCHED_PARTIAL_FLUSH_EN.
module pp_bank_sched #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096,
    parameter int CNT_W  = 16
) (
    input  logic           clk_50m,
    input  logic           usr_rst_n,
    pp_bank_sched_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t                  state_q, state_d;
    logic                    wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
    logic [1:0]              bank_full_q, bank_full_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [1:0][ADDR_W:0]    len_q, len_d;
    logic                    drop_pulse_q, drop_pulse_d;
    logic [CNT_W-1:0]        drop_cnt_q, drop_cnt_d;
    logic                    proto_err_q, proto_err_d;
    logic [1:0]              sync_q, sync_d;
    logic                    ref_q, ref_d;
    logic [1:0]              blank_q, blank_d;

    logic                    fill_beat;
    logic                    stall_beat;
    logic [1:0]              bank_wr_en;
    logic                    rel_edge;
    logic                    rel_ok;
    logic                    rel_err;
    logic                    last_beat;
    logic                    flush_close;
    logic                    close_bank;
    logic [ADDR_W:0]         close_len;

    // Reader toggle crosses from usr_clk; this chain is never reset.
    always_comb begin
        sync_d = {sync_q[0], bus.rd_done_tgl};
    end

    always_ff @(posedge clk_50m) begin
        sync_q <= sync_d;
    end

    // Edges are ignored while blank_q counts down, covering a toggle still inside the chain at reset.
    always_comb begin
        rel_edge = (sync_q[1] ^ ref_q) & (blank_q == 2'd0) & ~bus.soft_rst;
        rel_ok   = rel_edge & (|bank_full_q);
        rel_err  = rel_edge & ~(|bank_full_q);
    end

    always_comb begin
        fill_beat  = 1'b0;
        stall_beat = 1'b0;
        case (state_q)
            ST_FILL:  fill_beat  = bus.data_en & ~bus.soft_rst;
            ST_STALL: stall_beat = bus.data_en & ~bus.soft_rst;
            default:  ;
        endcase
        bank_wr_en = fill_beat ? (wr_bank_q ? 2'b10 : 2'b01) : 2'b00;
    end

    always_comb begin
        last_beat = fill_beat && (wr_addr_q == LAST_ADDR);
`ifdef PP_SCHED_PARTIAL_FLUSH_EN
        flush_close = (state_q == ST_FILL) && bus.flush && !bus.soft_rst &&
                      ((wr_addr_q != '0) || fill_beat);
`else
        flush_close = 1'b0;
`endif
        close_bank = last_beat | flush_close;
        close_len  = {1'b0, wr_addr_q} + (ADDR_W+1)'(fill_beat);
    end

`ifndef PP_SCHED_PARTIAL_FLUSH_EN
    logic unused_flush;
    assign unused_flush = bus.flush;
`endif

    always_comb begin
        wr_addr_d    = wr_addr_q;
        wr_bank_d    = wr_bank_q;
        bank_full_d  = bank_full_q;
        rd_ptr_d     = rd_ptr_q;
        len_d        = len_q;
        drop_pulse_d = stall_beat;
        drop_cnt_d   = drop_cnt_q;
        proto_err_d  = proto_err_q | rel_err;
        ref_d        = sync_q[1];
        blank_d      = (blank_q == 2'd0) ? 2'd0 : blank_q - 2'd1;

        if (stall_beat && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
        if (rel_ok) begin
            bank_full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d              = ~rd_ptr_q;
        end
        if (fill_beat) begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
        end
        // The bank being closed is never the one being released, so both updates stand.
        if (close_bank) begin
            bank_full_d[wr_bank_q] = 1'b1;
            len_d[wr_bank_q]       = close_len;
            wr_addr_d              = '0;
            wr_bank_d              = ~wr_bank_q;
        end
        if (bus.soft_rst) begin
            wr_addr_d    = '0;
            wr_bank_d    = 1'b0;
            bank_full_d  = 2'b00;
            rd_ptr_d     = 1'b0;
            len_d        = '0;
            drop_pulse_d = 1'b0;
            drop_cnt_d   = '0;
            proto_err_d  = 1'b0;
            blank_d      = 2'd2;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.enable) begin
                    state_d = bank_full_d[wr_bank_q] ? ST_STALL : ST_FILL;
                end
            end
            ST_FILL: begin
                if (!bus.enable) begin
                    state_d = ST_IDLE;
                end else if (close_bank && bank_full_d[wr_bank_d]) begin
                    state_d = ST_STALL;
                end
            end
            ST_STALL: begin
                if (!bus.enable) begin
                    state_d = ST_IDLE;
                end else if (!bank_full_d[wr_bank_q]) begin
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.soft_rst) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_50m or negedge usr_rst_n) begin
        if (!usr_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_50m or negedge usr_rst_n) begin
        if (!usr_rst_n) begin
            wr_addr_q    <= '0;
            wr_bank_q    <= 1'b0;
            bank_full_q  <= 2'b00;
            rd_ptr_q     <= 1'b0;
            len_q        <= '0;
            drop_pulse_q <= 1'b0;
            drop_cnt_q   <= '0;
            proto_err_q  <= 1'b0;
            ref_q        <= 1'b0;
            blank_q      <= 2'd2;
        end else begin
            wr_addr_q    <= wr_addr_d;
            wr_bank_q    <= wr_bank_d;
            bank_full_q  <= bank_full_d;
            rd_ptr_q     <= rd_ptr_d;
            len_q        <= len_d;
            drop_pulse_q <= drop_pulse_d;
            drop_cnt_q   <= drop_cnt_d;
            proto_err_q  <= proto_err_d;
            ref_q        <= ref_d;
            blank_q      <= blank_d;
        end
    end

    assign bus.bank_wr_en  = bank_wr_en;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.bank_full   = bank_full_q;
    assign bus.rd_bank_vld = |bank_full_q;
    assign bus.rd_bank_id  = rd_ptr_q;
    assign bus.rd_len      = len_q[rd_ptr_q];
    assign bus.drop_pulse  = drop_pulse_q;
    assign bus.drop_cnt    = drop_cnt_q;
    assign bus.proto_err   = proto_err_q;
endmodule

// File: tb/tb_pp_bank_sched.sv
// tb/tb_pp_bank_sched.sv - directed self-checking bench for pp_bank_sched
module tb_pp_bank_sched;
    logic clk_50m = 1'b0;
    logic usr_rst_n;
    int   errors = 0;
    int   checks = 0;

    pp_bank_sched_if #(.ADDR_W(12), .CNT_W(16)) bus ();

    pp_bank_sched #(.ADDR_W(12), .DEPTH(4096), .CNT_W(16)) dut (
        .clk_50m  (clk_50m),
        .usr_rst_n(usr_rst_n),
        .bus      (bus)
    );

    always #10 clk_50m = ~clk_50m;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] out_vec();
        return {31'd0, bus.bank_wr_en, bus.wr_addr, bus.bank_full, bus.rd_bank_vld,
                bus.rd_bank_id, bus.rd_len, bus.drop_pulse, bus.proto_err};
    endfunction

    function automatic logic [63:0] beat(input logic [1:0] en, input int addr);
        logic [11:0] a;
        a = 12'(addr);
        return {50'd0, en, a};
    endfunction

    int exp_addr;
    logic [1:0] exp_en;

    initial begin
        usr_rst_n       = 1'b0;
        bus.soft_rst    = 1'b0;
        bus.enable      = 1'b0;
        bus.data_en     = 1'b0;
        bus.flush       = 1'b0;
        bus.rd_done_tgl = 1'b0;
        repeat (3) @(negedge clk_50m);
        #1;
        chk("reset_outs", out_vec(), 64'd0);
        chk("reset_drop_cnt", 64'(bus.drop_cnt), 64'd0);
        usr_rst_n = 1'b1;
        repeat (3) @(negedge clk_50m);

        // release with nothing full
        bus.rd_done_tgl = 1'b1;
        repeat (4) @(negedge clk_50m);
        #1;
        chk("proto_err_set", 64'(bus.proto_err), 64'd1);
        chk("proto_flags", 64'(bus.bank_full), 64'd0);
        chk("proto_rd_id", 64'(bus.rd_bank_id), 64'd0);
        @(negedge clk_50m);
        bus.soft_rst = 1'b1;
        @(negedge clk_50m);
        bus.soft_rst = 1'b0;
        #1;
        chk("proto_err_clr", 64'(bus.proto_err), 64'd0);

        // first bank
        @(negedge clk_50m);
        bus.enable = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            @(negedge clk_50m);
            bus.data_en = 1'b1;
            #1;
            chk("fill_bank0", beat(bus.bank_wr_en, bus.wr_addr), beat(2'b01, i));
        end
        @(negedge clk_50m);
        bus.data_en = 1'b0;
        #1;
        chk("b0_full", 64'(bus.bank_full), 64'd1);
        chk("b0_vld", 64'(bus.rd_bank_vld), 64'd1);
        chk("b0_id", 64'(bus.rd_bank_id), 64'd0);
        chk("b0_len", 64'(bus.rd_len), 64'd4096);
        chk("b0_addr", 64'(bus.wr_addr), 64'd0);

        for (int i = 0; i < 4096; i++) begin
            @(negedge clk_50m);
            bus.data_en = 1'b1;
            #1;
            chk("fill_bank1", beat(bus.bank_wr_en, bus.wr_addr), beat(2'b10, i));
        end
        @(negedge clk_50m);
        bus.data_en = 1'b0;
        #1;
        chk("both_full", 64'(bus.bank_full), 64'd3);

        // both full: beats are dropped
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_50m);
            bus.data_en = 1'b1;
            #1;
            chk("stall_wr_en", 64'(bus.bank_wr_en), 64'd0);
            chk("stall_pulse", 64'(bus.drop_pulse), (k > 0) ? 64'd1 : 64'd0);
        end
        @(negedge clk_50m);
        bus.data_en = 1'b0;
        #1;
        chk("drop_pulse_last", 64'(bus.drop_pulse), 64'd1);
        chk("drop_cnt", 64'(bus.drop_cnt), 64'd10);
        @(negedge clk_50m);
        #1;
        chk("drop_pulse_end", 64'(bus.drop_pulse), 64'd0);

        // release bank 0
        @(negedge clk_50m);
        bus.rd_done_tgl = 1'b0;
        @(negedge clk_50m);
        @(negedge clk_50m);
        #1;
        chk("rel_2nd_edge", 64'(bus.bank_full), 64'd3);
        @(negedge clk_50m);
        #1;
        chk("rel_3rd_edge", 64'(bus.bank_full), 64'd2);
        chk("rel_rd_id", 64'(bus.rd_bank_id), 64'd1);
        chk("rel_vld", 64'(bus.rd_bank_vld), 64'd1);
        chk("rel_len", 64'(bus.rd_len), 64'd4096);
        bus.data_en = 1'b1;
        #1;
        chk("resume_beat", beat(bus.bank_wr_en, bus.wr_addr), beat(2'b01, 0));

        // soft reset mid-bank with a toggle in flight
        for (int i = 1; i < 1234; i++) @(negedge clk_50m);
        @(negedge clk_50m);
        bus.data_en     = 1'b0;
        bus.rd_done_tgl = 1'b1;
        #1;
        chk("pre_srst_addr", 64'(bus.wr_addr), 64'd1234);
        @(negedge clk_50m);
        bus.soft_rst = 1'b1;
        bus.data_en  = 1'b1;
        #1;
        chk("srst_gate", 64'(bus.bank_wr_en), 64'd0);
        @(negedge clk_50m);
        bus.soft_rst = 1'b0;
        bus.data_en  = 1'b0;
        #1;
        chk("srst_outs", out_vec(), 64'd0);
        chk("srst_drop_cnt", 64'(bus.drop_cnt), 64'd0);
        repeat (4) @(negedge clk_50m);
        #1;
        chk("no_spur_err", 64'(bus.proto_err), 64'd0);
        chk("no_spur_full", 64'(bus.bank_full), 64'd0);
        bus.data_en = 1'b1;
        #1;
        chk("srst_next_beat", beat(bus.bank_wr_en, bus.wr_addr), beat(2'b01, 0));

        // flush after 100 beats
        for (int i = 1; i < 100; i++) @(negedge clk_50m);
        @(negedge clk_50m);
        bus.data_en = 1'b0;
        bus.flush   = 1'b1;
        #1;
        chk("pre_flush_addr", 64'(bus.wr_addr), 64'd100);
        @(negedge clk_50m);
        bus.flush = 1'b0;
        #1;
`ifdef PP_SCHED_PARTIAL_FLUSH_EN
        chk("flush_full", 64'(bus.bank_full), 64'd1);
        chk("flush_len", 64'(bus.rd_len), 64'd100);
        exp_en   = 2'b10;
        exp_addr = 0;
`else
        chk("flush_full", 64'(bus.bank_full), 64'd0);
        chk("flush_len", 64'(bus.rd_len), 64'd0);
        exp_en   = 2'b01;
        exp_addr = 100;
`endif
        bus.data_en = 1'b1;
        #1;
        chk("post_flush_beat", beat(bus.bank_wr_en, bus.wr_addr), beat(exp_en, exp_addr));
        exp_addr = exp_addr + 1;

        // enable low: IDLE ignores beats, filling resumes at the retained address
        @(negedge clk_50m);
        bus.data_en = 1'b0;
        bus.enable  = 1'b0;
        @(negedge clk_50m);
        bus.data_en = 1'b1;
        #1;
        chk("idle_wr_en", 64'(bus.bank_wr_en), 64'd0);
        @(negedge clk_50m);
        #1;
        chk("idle_no_drop", 64'(bus.drop_pulse), 64'd0);
        chk("idle_drop_cnt", 64'(bus.drop_cnt), 64'd0);
        bus.data_en = 1'b0;
        bus.enable  = 1'b1;
        @(negedge clk_50m);
        bus.data_en = 1'b1;
        #1;
        chk("resume_addr", beat(bus.bank_wr_en, bus.wr_addr), beat(exp_en, exp_addr));
        @(negedge clk_50m);
        bus.data_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
